// File: rtl/conv33_output_framer.sv
// Frames 3x3 window sums from a raster pixel stream: keeps only windows fully inside
// the image, tags the frame's final window, and buffers results in a small FWFT FIFO.
module conv33_output_framer #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             overflow
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);

    logic [CW-1:0]  col_r;
    logic [RW-1:0]  row_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic [WIDTH:0] mem_r [DEPTH];

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic             frame_done_r;
    logic             overflow_r;

    logic           at_end_s;
    logic           qual_s;
    logic           pop_s;
    logic           full_s;
    logic           push_s;
    logic           drop_s;
    logic [AW:0]    count_next_s;
    logic [WIDTH:0] head_next_s;

    // Qualification and FIFO handshake decode for the current cycle.
    always_comb begin
        at_end_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
        qual_s   = in_valid && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
        pop_s    = out_valid_r && out_ready;
        full_s   = (count_r == CNT_FULL);
        push_s   = qual_s && (!full_s || pop_s);
        drop_s   = qual_s && full_s && !pop_s;
    end

    // Next occupancy and next head entry; the head is registered so outputs are flops.
    always_comb begin
        head_next_s  = {out_last_r, out_data_r};
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            // Popping the only entry: a same-cycle push becomes the new head directly.
            if (count_r == CNT_ONE) begin
                if (push_s) begin
                    head_next_s = {at_end_s, in_data};
                end else begin
                    head_next_s = {out_last_r, out_data_r};
                end
            end else begin
                head_next_s = mem_r[rd_ptr_r + AW'(1)];
            end
        end else if ((count_r == CNT_ZERO) && push_s) begin
            head_next_s = {at_end_s, in_data};
        end else begin
            head_next_s = {out_last_r, out_data_r};
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= {at_end_s, in_data};
        end
    end

    // Raster counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_r        <= CW'(0);
            row_r        <= RW'(0);
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            count_r      <= CNT_ZERO;
            out_valid_r  <= 1'b0;
            out_data_r   <= WIDTH'(0);
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (in_valid) begin
                if (col_r == COL_LAST) begin
                    col_r <= CW'(0);
                    if (row_r == ROW_LAST) begin
                        row_r <= RW'(0);
                    end else begin
                        row_r <= row_r + RW'(1);
                    end
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end else begin
                col_r <= col_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r      <= count_next_s;
            out_valid_r  <= (count_next_s != CNT_ZERO);
            out_last_r   <= head_next_s[WIDTH];
            out_data_r   <= head_next_s[WIDTH-1:0];
            frame_done_r <= in_valid && at_end_s;
            overflow_r   <= overflow_r || drop_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/conv33_output_framer.md
CONV33_OUTPUT_FRAMER -- requirements
Module: conv33_output_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of the window sum.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per row (min 3).
REQ-003 SHALL have parameter IMG_H, default 64, rows per frame (min 3).
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, min 2).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  upstream pixel strobe, one raster pixel per asserted cycle.
REQ-008 SHALL have port in_data  input  WIDTH  3x3 window sum whose bottom-right tap is the current pixel.
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid window result.
REQ-011 SHALL have port out_data  output  WIDTH  FIFO head data.
REQ-012 SHALL have port out_last  output  1  head entry is the frame's final valid window, at (IMG_H-1, IMG_W-1).
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the final pixel of a frame is counted.
REQ-014 SHALL have port overflow  output  1  sticky flag, set when a qualified result is dropped.

Function
REQ-015 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on in_valid=1 cycles.
REQ-016 col SHALL wrap from IMG_W-1 to 0 and increment row; at (IMG_H-1, IMG_W-1), both SHALL return to 0.
REQ-017 A pixel SHALL be qualified when in_valid=1, row>=2 and col>=2; non-qualified pixels SHALL be discarded silently.
REQ-018 A qualified in_data SHALL be pushed on the same rising edge with a last bit equal to (row==IMG_H-1 && col==IMG_W-1).
REQ-019 Latency SHALL be 1 cycle: a pushed entry into an empty FIFO gives out_valid=1 on the next cycle.
REQ-020 The FIFO SHALL be first-word-fall-through; out_data and out_last SHALL reflect the head entry whenever out_valid=1.
REQ-021 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-022 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Push and pop in the same cycle SHALL both occur, count unchanged, including when the FIFO is full.
REQ-024 A push when full with no pop SHALL drop the entry, leave FIFO contents unchanged, and set overflow=1.
REQ-025 overflow SHALL stay 1 until reset.
REQ-026 A dropped entry SHALL still advance counters, so frame alignment is preserved.
REQ-027 frame_done SHALL be 1 for exactly the cycle following the edge that counts pixel (IMG_H-1, IMG_W-1), regardless of FIFO state.
REQ-028 No arithmetic SHALL be applied to in_data; WIDTH bits SHALL pass unmodified.
REQ-029 One frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) pushes, absent drops.

Reset
REQ-030 While reset=0 at a rising edge, the block SHALL clear col, row, FIFO pointers and count.
REQ-031 While reset=0 at a rising edge, the block SHALL force out_valid=0, out_last=0, frame_done=0, overflow=0 and out_data=0.
REQ-032 Reset asserted mid-frame SHALL discard all FIFO contents.
REQ-033 The first in_valid pixel after reset release SHALL be counted as (0,0).
REQ-034 in_valid asserted during reset SHALL be ignored.

Verification
REQ-035 Frame count: IMG_W=4, IMG_H=4, in_valid=1 for 16 cycles, in_data=pixel index 0..15, out_ready=1 -> outputs 10,11,14,15 in order; out_last only with 15; frame_done one pulse after index 15.
REQ-036 Backpressure: as REQ-035 with out_ready=0 throughout -> out_valid=1 holding 10; FIFO fills to 4; overflow=0; then out_ready=1 -> 10,11,14,15 emitted on consecutive cycles.
REQ-037 Overflow: DEPTH=2, IMG_W=IMG_H=4, out_ready=0 -> 10,11 retained; 14 dropped with overflow=1; 15 dropped; frame_done still pulses; overflow remains 1 after draining.
REQ-038 Full push+pop: DEPTH=2 full with 10,11, out_ready=1 on the cycle 14 arrives -> 10 popped, 14 accepted, overflow=0.
REQ-039 Gapped input: in_valid toggling 1,0,1,0 across a frame -> same 4 outputs as REQ-035; counters advance only on valid cycles.
REQ-040 Mid-frame reset: reset=0 for 1 cycle after pixel 11 -> out_valid=0 next cycle; next 16 valid pixels yield 10,11,14,15 relative to the new frame.
